modexp_seq: RTL and testbench

- Hardware sequencer that runs one full RSA modular exponentiation with no testbench involvement.
- Triggers R mod n (rtMod, mode 0), then R^2 mod n (rtMod, mode 1), then n' (modInv), and latches each result.
- Streams m/e/n words from a 3-bank operand RAM, plus r/t words from its own registers, into ModExp, then streams the result words out.
- Sits between the host/bus wrapper and the rtMod, modInv and ModExp cores.

---
 rtl/modexp_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_modexp_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_seq.sv
// ============================================================================
// modexp_seq: runs one RSA modular exponentiation by sequencing the rtMod,
// modInv and ModExp cores and streaming the ModExp result words out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module modexp_seq #(
  parameter int WIDTH        = 4096,
  parameter int DATA_WIDTH   = 64,
  parameter int WORDS        = WIDTH / DATA_WIDTH,
  parameter int AW           = 6,
  parameter int TO_W         = 24,
  parameter int EXP_COMPLETE = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rt_go,
  output logic                  rt_mode,
  input  logic [WIDTH-1:0]      rt_r,
  input  logic                  rt_done,
  output logic                  inv_go,
  input  logic [63:0]           inv_val,
  input  logic                  inv_valid,
  output logic [AW-1:0]         op_rd_addr,
  input  logic [DATA_WIDTH-1:0] op_m_data,
  input  logic [DATA_WIDTH-1:0] op_e_data,
  input  logic [DATA_WIDTH-1:0] op_n_data,
  output logic [DATA_WIDTH-1:0] m_buf,
  output logic [DATA_WIDTH-1:0] e_buf,
  output logic [DATA_WIDTH-1:0] n_buf,
  output logic [DATA_WIDTH-1:0] r_buf,
  output logic [DATA_WIDTH-1:0] t_buf,
  output logic [63:0]           nprime0,
  output logic                  startInput,
  output logic                  startCompute,
  output logic                  getResult,
  input  logic [4:0]            exp_state,
  input  logic [DATA_WIDTH-1:0] res_out,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [AW-1:0]         res_idx
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CALC_R   = 3'd1,
    S_CALC_T   = 3'd2,
    S_CALC_N0  = 3'd3,
    S_LOAD     = 3'd4,
    S_WAIT_EXP = 3'd5,
    S_READ     = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  localparam logic [AW:0]   K_LAST   = (AW+1)'(WORDS);
  localparam logic [AW:0]   K_ONE    = (AW+1)'(1);
  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST  = {TO_W{1'b1}} - CNT_ONE;
  localparam logic [4:0]    EXP_CODE = 5'(EXP_COMPLETE);

  state_e             state_q, state_d;
  logic [AW:0]        k_q, k_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   r_q, r_d, t_q, t_d;
  logic [63:0]        nprime0_q, nprime0_d;
  logic               rt_go_q, rt_go_d, rt_mode_q, rt_mode_d, inv_go_q, inv_go_d;
  logic               start_input_q, start_input_d;
  logic               start_compute_q, start_compute_d;
  logic               get_result_q, get_result_d;
  logic               err_q, err_d;
  logic               abort;

  logic               w_timeout;
  logic               w_load_drive;
  logic               w_read_drive;
  logic [AW-1:0]      w_word;

  assign w_timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    cnt_d           = '0;
    r_d             = r_q;
    t_d             = t_q;
    nprime0_d       = nprime0_q;
    rt_go_d         = 1'b0;
    rt_mode_d       = rt_mode_q;
    inv_go_d        = 1'b0;
    start_input_d   = start_input_q;
    start_compute_d = start_compute_q;
    get_result_d    = get_result_q;
    err_d           = err_q;
    abort           = 1'b0;

    // Completions coinciding with their own go pulse are stale and ignored.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC_R;
          rt_go_d   = 1'b1;
          rt_mode_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_CALC_R: begin
        if (rt_done && !rt_go_q) begin
          r_d       = rt_r;
          state_d   = S_CALC_T;
          rt_go_d   = 1'b1;
          rt_mode_d = 1'b1;
        end else if (w_timeout) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CALC_T: begin
        if (rt_done && !rt_go_q) begin
          t_d      = rt_r;
          state_d  = S_CALC_N0;
          inv_go_d = 1'b1;
        end else if (w_timeout) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CALC_N0: begin
        if (inv_valid && !inv_go_q) begin
          nprime0_d       = inv_val;
          state_d         = S_LOAD;
          k_d             = '0;
          start_input_d   = 1'b1;
          start_compute_d = 1'b1;
        end else if (w_timeout) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LOAD: begin
        if (k_q == K_LAST) begin
          state_d      = S_WAIT_EXP;
          get_result_d = 1'b1;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_WAIT_EXP: begin
        if (exp_state == EXP_CODE) begin
          state_d = S_READ;
          k_d     = '0;
        end else if (w_timeout) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_READ: begin
        if (k_q == K_LAST) begin
          state_d         = S_DONE;
          err_d           = 1'b0;
          start_input_d   = 1'b0;
          start_compute_d = 1'b0;
          get_result_d    = 1'b0;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        rt_mode_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d         = S_DONE;
      err_d           = 1'b1;
      start_input_d   = 1'b0;
      start_compute_d = 1'b0;
      get_result_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      k_q             <= '0;
      cnt_q           <= '0;
      r_q             <= '0;
      t_q             <= '0;
      nprime0_q       <= '0;
      rt_go_q         <= 1'b0;
      rt_mode_q       <= 1'b0;
      inv_go_q        <= 1'b0;
      start_input_q   <= 1'b0;
      start_compute_q <= 1'b0;
      get_result_q    <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      cnt_q           <= cnt_d;
      r_q             <= r_d;
      t_q             <= t_d;
      nprime0_q       <= nprime0_d;
      rt_go_q         <= rt_go_d;
      rt_mode_q       <= rt_mode_d;
      inv_go_q        <= inv_go_d;
      start_input_q   <= start_input_d;
      start_compute_q <= start_compute_d;
      get_result_q    <= get_result_d;
      err_q           <= err_d;
    end
  end

  // Word k-1 is presented in LOAD/READ cycle k; the subtraction wraps 64 to 63.
  assign w_word       = k_q[AW-1:0] - AW'(1);
  assign w_load_drive = (state_q == S_LOAD) && (k_q != '0);
  assign w_read_drive = (state_q == S_READ) && (k_q != '0);

  assign op_rd_addr = ((state_q == S_LOAD) && (k_q != K_LAST)) ? k_q[AW-1:0] : '0;
  assign m_buf      = w_load_drive ? op_m_data : '0;
  assign e_buf      = w_load_drive ? op_e_data : '0;
  assign n_buf      = w_load_drive ? op_n_data : '0;
  assign r_buf      = w_load_drive ? r_q[w_word*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign t_buf      = w_load_drive ? t_q[w_word*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign res_valid  = w_read_drive;
  assign res_data   = w_read_drive ? res_out : '0;
  assign res_idx    = w_read_drive ? w_word : '0;

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_DONE) && err_q;
  assign rt_go        = rt_go_q;
  assign rt_mode      = rt_mode_q;
  assign inv_go       = inv_go_q;
  assign nprime0      = nprime0_q;
  assign startInput   = start_input_q;
  assign startCompute = start_compute_q;
  assign getResult    = get_result_q;

endmodule

`default_nettype wire

// File: tb/tb_modexp_seq.sv
// ============================================================================
// tb_modexp_seq: stubbed rtMod/modInv/ModExp/RAM around modexp_seq with a
// queue-based scoreboard for the result stream and completion status.
// ============================================================================
`default_nettype none

module tb_modexp_seq;

  localparam int WIDTH = 4096;
  localparam int DW    = 64;
  localparam int WORDS = 64;
  localparam int AW    = 6;
  localparam int TO_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, busy, done, err, rt_go, rt_mode, rt_done;
  logic [WIDTH-1:0] rt_r;
  logic             inv_go, inv_valid;
  logic [63:0]      inv_val, nprime0;
  logic [AW-1:0]    op_rd_addr, res_idx;
  logic [DW-1:0]    m_rd, e_rd, n_rd, m_buf, e_buf, n_buf, r_buf, t_buf, res_out, res_data;
  logic             startInput, startCompute, getResult, res_valid;
  logic [4:0]       exp_state;

  modexp_seq #(.WIDTH(WIDTH), .DATA_WIDTH(DW), .WORDS(WORDS), .AW(AW), .TO_W(TO_W), .EXP_COMPLETE(9)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .rt_go(rt_go), .rt_mode(rt_mode), .rt_r(rt_r), .rt_done(rt_done),
    .inv_go(inv_go), .inv_val(inv_val), .inv_valid(inv_valid),
    .op_rd_addr(op_rd_addr), .op_m_data(m_rd), .op_e_data(e_rd), .op_n_data(n_rd),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
    .nprime0(nprime0), .startInput(startInput), .startCompute(startCompute),
    .getResult(getResult), .exp_state(exp_state), .res_out(res_out),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0]      mem_m [WORDS];
  logic [63:0]      mem_e [WORDS];
  logic [63:0]      mem_n [WORDS];
  logic [WIDTH-1:0] r_val, t_val;
  logic [63:0]      inv_val_cfg, last_np;
  bit               inv_en;
  int               exp_delay;

  logic [63:0] exp_data_q[$];
  logic [AW-1:0] exp_idx_q[$];
  bit          exp_err_q[$];

  int  rt_go_cnt, inv_go_cnt, res_cnt, done_cnt, inv_go_cyc;
  bit  rt_modes[4];
  bit  to_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=none required=event", name);
  endtask

  // Reference: square-and-multiply on the operand RAM contents.
  function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [63:0] e, input logic [63:0] n);
    logic [127:0] r, x;
    r = 128'd1 % n;
    x = b % n;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % n;
      x = (x * x) % n;
    end
    return r[63:0];
  endfunction

  function automatic logic [63:0] slow_pow(input logic [63:0] b, input logic [63:0] e, input logic [63:0] n);
    logic [127:0] acc;
    if (n == 0 || e > 64'd5000) return 64'hDEAD_BEEF_0BAD_F00D;
    acc = 128'd1 % n;
    for (longint i = 0; i < longint'(e); i++) acc = (acc * (b % n)) % n;
    return acc[63:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    m_rd <= mem_m[op_rd_addr];
    e_rd <= mem_e[op_rd_addr];
    n_rd <= mem_n[op_rd_addr];
  end

  // rtMod stub: done is level-sticky until the next go, so stale completions are present.
  int rt_cnt;
  logic rt_m;
  always @(posedge clk) begin
    if (reset) begin
      rt_cnt <= 0; rt_done <= 1'b0; rt_r <= '0; rt_m <= 1'b0;
    end else if (rt_go) begin
      rt_cnt <= 5; rt_done <= 1'b0; rt_m <= rt_mode;
    end else if (rt_cnt != 0) begin
      rt_cnt <= rt_cnt - 1;
      if (rt_cnt == 2) begin
        rt_done <= 1'b1;
        rt_r    <= rt_m ? t_val : r_val;
      end
    end
  end

  int inv_cnt;
  always @(posedge clk) begin
    if (reset) begin
      inv_cnt <= 0; inv_valid <= 1'b0; inv_val <= '0;
    end else if (inv_go) begin
      inv_cnt <= 4; inv_valid <= 1'b0;
    end else if (inv_cnt != 0) begin
      inv_cnt <= inv_cnt - 1;
      if (inv_cnt == 2 && inv_en) begin
        inv_valid <= 1'b1;
        inv_val   <= inv_val_cfg;
      end
    end
  end

  // ModExp stub: captures the LOAD stream, then computes from what it received.
  int          cap_n, bad_m, bad_e, bad_n, bad_r, bad_t, bad_a;
  bit          got_res;
  logic [63:0] cm [WORDS];
  logic [63:0] ce [WORDS];
  logic [63:0] cn [WORDS];
  logic [63:0] res_words [WORDS];

  always @(negedge clk) begin
    if (reset || !startInput) begin
      cap_n = 0; got_res = 0;
      bad_m = 0; bad_e = 0; bad_n = 0; bad_r = 0; bad_t = 0; bad_a = 0;
    end else if (!getResult) begin
      if (op_rd_addr !== ((cap_n < WORDS) ? AW'(cap_n) : '0)) bad_a++;
      if (cap_n > 0 && cap_n <= WORDS) begin
        cm[cap_n-1] = m_buf; ce[cap_n-1] = e_buf; cn[cap_n-1] = n_buf;
        if (m_buf !== mem_m[cap_n-1]) bad_m++;
        if (e_buf !== mem_e[cap_n-1]) bad_e++;
        if (n_buf !== mem_n[cap_n-1]) bad_n++;
        if (r_buf !== r_val[(cap_n-1)*DW +: DW]) bad_r++;
        if (t_buf !== t_val[(cap_n-1)*DW +: DW]) bad_t++;
      end
      cap_n++;
    end else if (!got_res) begin
      got_res = 1;
      chk("load_cycles", 64'(cap_n), 64'd65);
      chk("load_addr_bad", 64'(bad_a), 0);
      chk("load_m_bad", 64'(bad_m), 0);
      chk("load_e_bad", 64'(bad_e), 0);
      chk("load_n_bad", 64'(bad_n), 0);
      chk("load_r_bad", 64'(bad_r), 0);
      chk("load_t_bad", 64'(bad_t), 0);
      chk("load_start_compute", 64'(startCompute), 64'd1);
      res_words[0] = slow_pow(cm[0], ce[0], cn[0]);
      for (int i = 1; i < WORDS; i++) res_words[i] = cm[i] ^ ce[i] ^ cn[i];
    end
  end

  int ex_wait, rd_n;
  always @(posedge clk) begin
    if (reset || !getResult) begin
      exp_state <= 5'd0; ex_wait <= 0; rd_n <= 0; res_out <= '0;
    end else if (exp_state != 5'd9) begin
      exp_state <= (ex_wait >= exp_delay) ? 5'd9 : 5'd3;
      ex_wait   <= ex_wait + 1;
    end else begin
      rd_n    <= rd_n + 1;
      res_out <= (rd_n >= 1 && rd_n <= WORDS) ? res_words[rd_n-1] : {$urandom, $urandom};
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid) begin
        res_cnt++;
        if (exp_data_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL res_unexpected actual=%h required=no_word", res_data);
        end else begin
          chk("res_data", res_data, exp_data_q.pop_front());
          chk("res_idx", 64'(res_idx), 64'(exp_idx_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 64'(busy), 0);
        chk("done_ctrl", 64'({startInput, startCompute, getResult, rt_go, inv_go}), 0);
        if (exp_err_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected actual=done required=no_done");
        end else begin
          chk("err", 64'(err), 64'(exp_err_q.pop_front()));
        end
        if (to_mode) chk("timeout_latency", 64'(cyc - inv_go_cyc), 64'd255);
      end
      if (rt_go) begin
        if (rt_go_cnt < 4) rt_modes[rt_go_cnt] = rt_mode;
        rt_go_cnt++;
      end
      if (inv_go) begin
        inv_go_cnt++;
        inv_go_cyc = cyc;
      end
    end
  end

  task automatic setup(input bit directed);
    for (int i = 0; i < WORDS; i++) begin
      mem_m[i] = directed ? 64'd0 : {$urandom, $urandom};
      mem_e[i] = directed ? 64'd0 : {$urandom, $urandom};
      mem_n[i] = directed ? 64'd0 : {$urandom, $urandom};
    end
    if (directed) begin
      mem_m[0] = 64'd8; mem_e[0] = 64'd13; mem_n[0] = 64'd77;
      r_val = {512{8'hAA}}; t_val = {512{8'h55}};
      inv_val_cfg = 64'h1234_5678_9ABC_DEF0;
      exp_delay = 3;
    end else begin
      mem_n[0] = 64'($urandom | 32'h8000_0001);
      mem_m[0] = 64'($urandom) % mem_n[0];
      mem_e[0] = 64'($urandom_range(1, 2000));
      for (int i = 0; i < WIDTH/32; i++) begin
        r_val[i*32 +: 32] = $urandom;
        t_val[i*32 +: 32] = $urandom;
      end
      inv_val_cfg = {$urandom, $urandom};
      exp_delay = $urandom_range(1, 10);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_seq(input bit expect_to, input bit pokes);
    int n, d0;
    if (!expect_to)
      for (int i = 0; i < WORDS; i++) begin
        exp_data_q.push_back(i == 0 ? ref_pow(mem_m[0], mem_e[0], mem_n[0])
                                    : (mem_m[i] ^ mem_e[i] ^ mem_n[i]));
        exp_idx_q.push_back(AW'(i));
      end
    exp_err_q.push_back(expect_to);
    rt_go_cnt = 0; inv_go_cnt = 0; res_cnt = 0; d0 = done_cnt; to_mode = expect_to;
    rt_modes[0] = 1'b1; rt_modes[1] = 1'b0;
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    if (pokes) begin
      n = 0;
      while (!(rt_mode && !rt_go) && n < 200) begin @(negedge clk); n++; end
      pulse_start();
      n = 0;
      while (!res_valid && n < 500) begin @(negedge clk); n++; end
      pulse_start();
    end
    n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    if (!done) fail_now("done_wait");
    repeat (20) @(negedge clk);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("rt_go_pulses", 64'(rt_go_cnt), 64'd2);
    chk("rt_mode_seq", 64'({rt_modes[0], rt_modes[1]}), 64'b01);
    chk("inv_go_pulses", 64'(inv_go_cnt), 64'd1);
    chk("busy_after_done", 64'(busy), 0);
    chk("res_valid_cycles", 64'(res_cnt), expect_to ? 64'd0 : 64'd64);
    chk("exp_queue_left", 64'(exp_data_q.size()), 0);
    if (!expect_to) begin
      chk("nprime0", nprime0, inv_val_cfg);
      last_np = inv_val_cfg;
    end else begin
      chk("nprime0_kept", nprime0, last_np);
    end
  endtask

  task automatic check_idle(input string p);
    chk({p, "_ctrl"}, 64'({busy, done, err, rt_go, rt_mode, inv_go, startInput,
                          startCompute, getResult, res_valid}), 0);
    chk({p, "_nprime0"}, nprime0, 0);
    chk({p, "_bufs"}, m_buf | e_buf | n_buf | r_buf | t_buf | res_data, 0);
    chk({p, "_addr"}, 64'({op_rd_addr, res_idx}), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; inv_en = 1'b1; to_mode = 1'b0;
    done_cnt = 0; rt_go_cnt = 0; inv_go_cnt = 0; res_cnt = 0; inv_go_cyc = 0;
    last_np = '0;
    setup(1'b1);
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    run_seq(1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      setup(1'b0);
      run_seq(1'b0, r == 1);
    end

    setup(1'b0);
    inv_en = 1'b0;
    run_seq(1'b1, 1'b0);
    inv_en = 1'b1;

    setup(1'b0);
    pulse_start();
    n = 0;
    while (!startInput && n < 200) begin @(negedge clk); n++; end
    if (!startInput) fail_now("load_wait");
    repeat (30) @(negedge clk);
    chk("load_k30_addr", 64'(op_rd_addr), 64'd30);
    reset = 1'b1;
    @(negedge clk);
    check_idle("abort");
    reset = 1'b0;
    n = done_cnt;
    repeat (100) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - n), 0);

    setup(1'b0);
    run_seq(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
